instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/instruction_fetch_pc_next_calc.sv | 26 ++
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, word/displacement widths and the default reset PC.
package instruction_fetch_pkg;

  localparam int WORD_W = 16;
  localparam int DISP_W = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [DISP_W-1:0] disp_t;

  localparam word_t DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_VALID
  } fetch_state_t;

  function automatic word_t sext_disp(input disp_t d);
    return {{(WORD_W-DISP_W){d[DISP_W-1]}}, d};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_next_calc.sv
// Combinational next-PC selection: absolute jump beats relative branch,
// displacement is sign-extended and the sum wraps modulo 2^16.
module pc_next_calc
  import instruction_fetch_pkg::*;
(
  input  word_t i_pc,
  input  logic  i_pc_write,
  input  logic  i_pc_increment,
  input  disp_t i_imm,
  input  word_t i_target,
  output word_t o_next_pc,
  output logic  o_update
);

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    o_update  = i_pc_write | i_pc_increment;
    o_next_pc = i_pc;
    if (i_pc_write) begin
      o_next_pc = i_target;
    end else if (i_pc_increment) begin
      o_next_pc = i_pc + sext_disp(i_imm);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register, IDLE/FETCH/VALID handshake with
// instruction memory and the instruction register. Optional fetch
// watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter word_t RESET_PC       = DEFAULT_RESET_PC,
  parameter int    TIMEOUT_CYCLES = 15
) (
  input  logic  Clock,
  input  logic  Reset,
  input  logic  IRWrite,
  input  logic  PCIncrement,
  input  logic  PCWrite,
  input  disp_t PCImmediate,
  input  word_t PCTarget,
  input  word_t MemData,
  input  logic  MemReady,
  output logic  MemRead,
  output word_t MemAddr,
  output word_t INS,
  output word_t PC,
  output logic  InsValid,
  output logic  Busy,
  output logic  Fault
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fetch_state_t r_state;
  word_t        r_pc;
  word_t        r_ins;
  logic         r_ins_valid;
  logic         r_busy;

  word_t        w_next_pc;
  logic         w_pc_update;

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_timeout_cnt;
  logic            r_fault;
`endif

  pc_next_calc u_pc_next_calc (
    .i_pc          (r_pc),
    .i_pc_write    (PCWrite),
    .i_pc_increment(PCIncrement),
    .i_imm         (PCImmediate),
    .i_target      (PCTarget),
    .o_next_pc     (w_next_pc),
    .o_update      (w_pc_update)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_ins       <= '0;
      r_ins_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_timeout_cnt <= '0;
      r_fault       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pc_update) begin
            r_pc <= w_next_pc;
          end
          if (IRWrite) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
          end
        end

        // PC is frozen here so MemAddr stays stable for the whole request.
        ST_FETCH: begin
          if (MemReady) begin
            r_ins       <= MemData;
            r_ins_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_VALID;
`ifdef FETCH_TIMEOUT_EN
            r_timeout_cnt <= '0;
          end else if (r_timeout_cnt == TO_LAST) begin
            r_fault       <= 1'b1;
            r_ins         <= '0;
            r_ins_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
            r_timeout_cnt <= '0;
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
`endif
          end
        end

        ST_VALID: begin
          if (w_pc_update) begin
            r_pc        <= w_next_pc;
            r_ins_valid <= 1'b0;
            if (IRWrite) begin
              r_state <= ST_FETCH;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (IRWrite) begin
            r_ins_valid <= 1'b0;
            r_state     <= ST_FETCH;
            r_busy      <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign MemRead  = r_busy;
  assign Busy     = r_busy;
  assign MemAddr  = r_pc;
  assign PC       = r_pc;
  assign INS      = r_ins;
  assign InsValid = r_ins_valid;

`ifdef FETCH_TIMEOUT_EN
  assign Fault = r_fault;
`else
  assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: scoreboard of expected
// instructions, bench-side PC model, reset/priority/wrap/timeout scenarios.
module tb_instruction_fetch;

  localparam logic [15:0] TB_RESET_PC = 16'h0000;
  localparam int          TB_TIMEOUT  = 15;

  logic        Clock = 1'b0;
  logic        Reset, IRWrite, PCIncrement, PCWrite, MemReady;
  logic [7:0]  PCImmediate;
  logic [15:0] PCTarget, MemData;
  logic        MemRead, InsValid, Busy, Fault;
  logic [15:0] MemAddr, INS, PC;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_pc;

  instruction_fetch #(
    .RESET_PC      (TB_RESET_PC),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .IRWrite    (IRWrite),
    .PCIncrement(PCIncrement),
    .PCWrite    (PCWrite),
    .PCImmediate(PCImmediate),
    .PCTarget   (PCTarget),
    .MemData    (MemData),
    .MemReady   (MemReady),
    .MemRead    (MemRead),
    .MemAddr    (MemAddr),
    .INS        (INS),
    .PC         (PC),
    .InsValid   (InsValid),
    .Busy       (Busy),
    .Fault      (Fault)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    Reset       = 1'b0;
    IRWrite     = 1'b0;
    PCIncrement = 1'b0;
    PCWrite     = 1'b0;
    PCImmediate = 8'h00;
    PCTarget    = 16'h0000;
    MemData     = 16'h0000;
    MemReady    = 1'b0;
  endtask

  function automatic logic [15:0] add_disp(input logic [15:0] pc, input logic [7:0] d);
    return pc + {{8{d[7]}}, d};
  endfunction

  // Starts in FETCH; holds MemReady low for wait_cycles, then answers with data.
  task automatic complete_fetch(input int wait_cycles, input logic [15:0] data, input string tag);
    exp_t got;
    checks++;
    if (MemRead !== 1'b1 || Busy !== 1'b1 || MemAddr !== m_pc) begin
      errors++;
      $display("FAIL %s_fetch_start: MemRead=%b Busy=%b MemAddr=%h, want 1 1 %h", tag, MemRead, Busy, MemAddr, m_pc);
    end
    repeat (wait_cycles) tick();
    checks++;
    if (PC !== m_pc || InsValid !== 1'b0) begin
      errors++;
      $display("FAIL %s_fetch_wait: PC=%h InsValid=%b, want %h 0", tag, PC, InsValid, m_pc);
    end
    MemReady = 1'b1;
    MemData  = data;
    sb.push_back('{pc: m_pc, ins: data});
    tick();
    MemReady = 1'b0;
    MemData  = 16'h0000;
    checks++;
    if (InsValid !== 1'b1) begin
      errors++;
      $display("FAIL %s_ins_valid: InsValid=%b, want 1", tag, InsValid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard_empty: InsValid=1 with no expected entry", tag);
    end else begin
      got = sb.pop_front();
      if (INS !== got.ins || PC !== got.pc || Busy !== 1'b0) begin
        errors++;
        $display("FAIL %s_ins: INS=%h PC=%h Busy=%b, want %h %h 0", tag, INS, PC, Busy, got.ins, got.pc);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b1;
    IRWrite = 1'b1;
    PCWrite = 1'b1;
    PCTarget = 16'h5555;
    tick();
    tick();
    clear_inputs();
    m_pc = TB_RESET_PC;
    checks++;
    if (PC !== TB_RESET_PC || INS !== 16'h0000 || InsValid !== 1'b0 ||
        MemRead !== 1'b0 || Busy !== 1'b0 || Fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: PC=%h INS=%h V=%b MR=%b B=%b F=%b, want %h 0000 0 0 0 0",
               PC, INS, InsValid, MemRead, Busy, Fault, TB_RESET_PC);
    end
  endtask

  task automatic test_basic_fetch();
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    checks++;
    if (MemAddr !== 16'h0000) begin
      errors++;
      $display("FAIL basic_memaddr: MemAddr=%h, want 0000", MemAddr);
    end
    complete_fetch(2, 16'h5123, "basic");
  endtask

  task automatic test_pc_increment();
    PCWrite = 1'b1; PCTarget = 16'h0010;
    tick();
    clear_inputs();
    m_pc = 16'h0010;
    checks++;
    if (PC !== 16'h0010 || InsValid !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL jump_from_valid: PC=%h V=%b B=%b, want 0010 0 0", PC, InsValid, Busy);
    end
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    complete_fetch(0, 16'h1111, "at0010");
    PCIncrement = 1'b1; PCImmediate = 8'hFC;
    tick();
    clear_inputs();
    m_pc = add_disp(m_pc, 8'hFC);
    checks++;
    if (PC !== 16'h000C || m_pc !== PC || InsValid !== 1'b0 || Busy !== 1'b0 || MemRead !== 1'b0) begin
      errors++;
      $display("FAIL incr_neg: PC=%h V=%b B=%b MR=%b, want 000c 0 0 0", PC, InsValid, Busy, MemRead);
    end
    MemReady = 1'b1; MemData = 16'hDEAD;
    tick();
    clear_inputs();
    checks++;
    if (InsValid !== 1'b0 || Busy !== 1'b0 || INS === 16'hDEAD) begin
      errors++;
      $display("FAIL memready_in_idle: V=%b B=%b INS=%h, want 0 0 and INS not dead", InsValid, Busy, INS);
    end
  endtask

  task automatic test_priority();
    PCWrite = 1'b1; PCTarget = 16'h1234;
    PCIncrement = 1'b1; PCImmediate = 8'h01;
    tick();
    clear_inputs();
    m_pc = 16'h1234;
    checks++;
    if (PC !== 16'h1234 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL write_priority: PC=%h Busy=%b, want 1234 0", PC, Busy);
    end
  endtask

  task automatic test_wrap();
    PCWrite = 1'b1; PCTarget = 16'hFFFF;
    tick();
    clear_inputs();
    PCIncrement = 1'b1; PCImmediate = 8'h01;
    tick();
    clear_inputs();
    checks++;
    if (PC !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_up: PC=%h, want 0000", PC);
    end
    PCIncrement = 1'b1; PCImmediate = 8'hFF;
    tick();
    clear_inputs();
    m_pc = 16'hFFFF;
    checks++;
    if (PC !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_down: PC=%h, want ffff", PC);
    end
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    PCWrite = 1'b1; PCTarget = 16'hBEEF; PCIncrement = 1'b1; PCImmediate = 8'h10;
    tick();
    clear_inputs();
    checks++;
    if (PC !== 16'hFFFF || MemAddr !== 16'hFFFF || Busy !== 1'b1) begin
      errors++;
      $display("FAIL write_in_fetch: PC=%h MemAddr=%h Busy=%b, want ffff ffff 1", PC, MemAddr, Busy);
    end
    complete_fetch(1, 16'h7777, "atffff");
  endtask

  task automatic test_refetch_and_update();
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    checks++;
    if (InsValid !== 1'b0 || PC !== 16'hFFFF) begin
      errors++;
      $display("FAIL refetch: V=%b PC=%h, want 0 ffff", InsValid, PC);
    end
    complete_fetch(0, 16'h8888, "refetch");
    PCIncrement = 1'b1; PCImmediate = 8'h02; IRWrite = 1'b1;
    tick();
    clear_inputs();
    m_pc = add_disp(m_pc, 8'h02);
    checks++;
    if (PC !== 16'h0001) begin
      errors++;
      $display("FAIL update_and_fetch_valid: PC=%h, want 0001", PC);
    end
    complete_fetch(1, 16'h9999, "newpc_valid");
    PCWrite = 1'b1; PCTarget = 16'h0200;
    tick();
    clear_inputs();
    PCWrite = 1'b1; PCTarget = 16'h0300; IRWrite = 1'b1;
    tick();
    clear_inputs();
    m_pc = 16'h0300;
    complete_fetch(0, 16'hA0A0, "newpc_idle");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  imm;
    logic [15:0] data;
    for (int i = 0; i < 8; i++) begin
      imm  = 8'($urandom_range(0, 255));
      data = 16'($urandom);
      PCIncrement = 1'b1; PCImmediate = imm; IRWrite = 1'b1;
      tick();
      clear_inputs();
      m_pc = add_disp(m_pc, imm);
      complete_fetch(int'($urandom_range(0, 3)), data, "b2b");
    end
  endtask

  task automatic test_timeout();
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    repeat (TB_TIMEOUT - 1) tick();
    checks++;
    if (Fault !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: Fault=%b Busy=%b, want 0 1", Fault, Busy);
    end
    tick();
    checks++;
    if (Fault !== 1'b1 || Busy !== 1'b0 || InsValid !== 1'b0 || INS !== 16'h0000) begin
      errors++;
      $display("FAIL timeout_fire: F=%b B=%b V=%b INS=%h, want 1 0 0 0000", Fault, Busy, InsValid, INS);
    end
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    complete_fetch(0, 16'h4242, "after_fault");
    checks++;
    if (Fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: Fault=%b, want 1", Fault);
    end
    Reset = 1'b1;
    tick();
    clear_inputs();
    m_pc = TB_RESET_PC;
    checks++;
    if (Fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_reset: Fault=%b, want 0", Fault);
    end
`else
    repeat (3 * TB_TIMEOUT) tick();
    checks++;
    if (Fault !== 1'b0 || Busy !== 1'b1 || MemRead !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout: F=%b B=%b MR=%b, want 0 1 1", Fault, Busy, MemRead);
    end
    complete_fetch(0, 16'h4242, "long_wait");
`endif
  endtask

  task automatic test_reset_mid_fetch();
    PCWrite = 1'b1; PCTarget = 16'h0777; IRWrite = 1'b1;
    tick();
    clear_inputs();
    Reset = 1'b1; MemReady = 1'b1; MemData = 16'hABCD;
    tick();
    clear_inputs();
    m_pc = TB_RESET_PC;
    checks++;
    if (INS !== 16'h0000 || PC !== TB_RESET_PC || InsValid !== 1'b0 || Busy !== 1'b0 || MemRead !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fetch: INS=%h PC=%h V=%b B=%b MR=%b, want 0000 %h 0 0 0",
               INS, PC, InsValid, Busy, MemRead, TB_RESET_PC);
    end
  endtask

  initial begin
    clear_inputs();
    m_pc = TB_RESET_PC;
    test_reset();
    test_basic_fetch();
    test_pc_increment();
    test_priority();
    test_wrap();
    test_refetch_and_update();
    test_back_to_back();
    test_timeout();
    test_reset_mid_fetch();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
